sample_streamer: RTL

Capture block downstream of `compute_blk`. Samples `dac_ch1`/`dac_ch2` on each `comp_ready` pulse, with optional decimation. Packs two sample pairs into one `DMA_WIDTH` beat and buffers the beats in a FIFO. Sends exactly `frame_len` beats per capture on an AXI-Stream master, with `tlast` on the final beat, so the DMA can return simulated-plant waveforms to the host.

---
 rtl/sample_streamer_pkg.sv | 18 +
 rtl/sample_streamer_sync_fifo.sv | 42 ++++
 rtl/sample_streamer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sample_streamer_pkg.sv
// Shared constants and FSM encoding for the sample_streamer capture path.
// Beats always carry two 32-bit sample-pair words.
package sample_streamer_pkg;

    localparam int DMA_WIDTH_DEF  = 64;
    localparam int SAMPLE_W_DEF   = 14;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int HALF_W         = 16;
    localparam int WORD_W         = 32;
    localparam int CHANNELS       = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_streamer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is readable whenever
// empty is low. Caller only writes when not full (or when popping the same cycle).
module sample_streamer_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/sample_streamer.sv
// Captures decimated DAC sample pairs, packs two per beat and streams exactly
// frame_len beats per capture over AXI-Stream with tlast on the final beat.
module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int DMA_WIDTH  = DMA_WIDTH_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [15:0]          frame_len,
    input  logic [7:0]           decimation,
    input  logic                 comp_ready,
    input  logic [SAMPLE_W-1:0]  dac_ch1,
    input  logic [SAMPLE_W-1:0]  dac_ch2,
    output logic [DMA_WIDTH-1:0] m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 overflow
);
    state_t               state_reg, state_next;
    logic [15:0]          frame_len_reg;
    logic [15:0]          beat_cnt_reg;
    logic [7:0]           decim_reg;
    logic [7:0]           dec_cnt_reg;
    logic                 half_reg;
    logic [WORD_W-1:0]    low_reg;
    logic                 push_valid_reg;
    logic [DMA_WIDTH:0]   push_data_reg;
    logic                 overflow_reg;

    logic [SAMPLE_W-1:0]  ch [CHANNELS];
    logic [WORD_W-1:0]    word;
    logic                 capture_hit;
    logic                 tlast_calc;
    logic                 pop;
    logic                 accept;
    logic [DMA_WIDTH:0]   fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign ch[0] = dac_ch1;
    assign ch[1] = dac_ch2;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_sext
            assign word[gi*HALF_W +: HALF_W] =
                {{(HALF_W-SAMPLE_W){ch[gi][SAMPLE_W-1]}}, ch[gi]};
        end
    endgenerate

    assign capture_hit = (state_reg == ST_CAPTURE) && en && comp_ready;
    assign tlast_calc  = (beat_cnt_reg == frame_len_reg - 16'd1);
    assign pop         = !fifo_empty && m_axis_tready;
    // A pending beat may enter a full FIFO when the head leaves in the same cycle.
    assign accept      = push_valid_reg && (!fifo_full || pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_CAPTURE;
            ST_CAPTURE: if (accept && push_data_reg[DMA_WIDTH]) state_next = ST_DRAIN;
            ST_DRAIN:   if (pop && fifo_rd[DMA_WIDTH]) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            frame_len_reg  <= 16'd1;
            beat_cnt_reg   <= '0;
            decim_reg      <= '0;
            dec_cnt_reg    <= '0;
            half_reg       <= 1'b0;
            low_reg        <= '0;
            push_valid_reg <= 1'b0;
            push_data_reg  <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            push_valid_reg <= 1'b0;
            if (accept) beat_cnt_reg <= beat_cnt_reg + 16'd1;
            if (push_valid_reg && !accept) overflow_reg <= 1'b1;

            if (state_reg == ST_IDLE && start) begin
                frame_len_reg <= (frame_len == 16'd0) ? 16'd1 : frame_len;
                decim_reg     <= decimation;
                dec_cnt_reg   <= '0;
                beat_cnt_reg  <= '0;
                half_reg      <= 1'b0;
                overflow_reg  <= 1'b0;
            end else if (capture_hit) begin
                if (dec_cnt_reg == 8'd0) begin
                    dec_cnt_reg <= decim_reg;
                    if (half_reg) begin
                        push_valid_reg <= 1'b1;
                        push_data_reg  <= {tlast_calc, word, low_reg};
                        half_reg       <= 1'b0;
                    end else begin
                        low_reg  <= word;
                        half_reg <= 1'b1;
                    end
                end else begin
                    dec_cnt_reg <= dec_cnt_reg - 8'd1;
                end
            end
        end
    end

    sample_streamer_sync_fifo #(
        .WIDTH (DMA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (push_data_reg),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd[DMA_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_rd[DMA_WIDTH];
    assign m_axis_tkeep  = 8'hFF;
    assign busy          = (state_reg != ST_IDLE);
    assign overflow      = overflow_reg;

endmodule
